// File: rtl/codificador42_seq.sv
// Debounced 4-to-2 priority encoder: a request must hold for STABLE_N samples before
// its code is reported, and is then held until ack. Optional CODIFICADOR42_MULTI_EN adds the multi flag.
module codificador42_seq #(
  parameter int STABLE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d,
  input  logic       ack,
  output logic [1:0] y,
  output logic       valid
`ifdef CODIFICADOR42_MULTI_EN
  ,
  output logic       multi
`endif
);

  typedef enum logic [1:0] {IDLE, FILTER, HOLD, RELEASE} state_t;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_N);

  state_t     state_reg, state_next;
  logic [3:0] d_q_reg;
  logic [3:0] cand_reg, cand_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] cnt_inc;
  logic [1:0] y_reg, y_next;
  logic       valid_reg, valid_next;

  function automatic logic [1:0] encode(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign cnt_inc = cnt_reg + 4'd1;

`ifdef CODIFICADOR42_MULTI_EN
  logic multi_reg, multi_next;
  assign multi = multi_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      d_q_reg   <= 4'd0;
      cand_reg  <= 4'd0;
      cnt_reg   <= 4'd0;
      y_reg     <= 2'd0;
      valid_reg <= 1'b0;
`ifdef CODIFICADOR42_MULTI_EN
      multi_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      d_q_reg   <= d;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      y_reg     <= y_next;
      valid_reg <= valid_next;
`ifdef CODIFICADOR42_MULTI_EN
      multi_reg <= multi_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;
    valid_next = valid_reg;
`ifdef CODIFICADOR42_MULTI_EN
    multi_next = multi_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (en && d_q_reg != 4'd0) begin
          cand_next  = d_q_reg;
          cnt_next   = 4'd1;
          state_next = FILTER;
        end
      end
      FILTER: begin
        if (!en) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else if (d_q_reg == cand_reg) begin
          cnt_next = cnt_inc;
          // Count saturates here: reaching STABLE_N leaves FILTER on the same edge.
          if (cnt_inc == STABLE_CNT) begin
            state_next = HOLD;
            y_next     = encode(cand_reg);
            valid_next = 1'b1;
`ifdef CODIFICADOR42_MULTI_EN
            multi_next = (cand_reg & (cand_reg - 4'd1)) != 4'd0;
`endif
          end
        end else if (d_q_reg == 4'd0) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else begin
          cand_next = d_q_reg;
          cnt_next  = 4'd1;
        end
      end
      HOLD: begin
        if (ack) begin
          state_next = RELEASE;
          valid_next = 1'b0;
`ifdef CODIFICADOR42_MULTI_EN
          multi_next = 1'b0;
`endif
        end
      end
      RELEASE: begin
        // The same request must go away before it can be reported again.
        if (d_q_reg == 4'd0) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign y     = y_reg;
  assign valid = valid_reg;

endmodule
